bucket_tx_scheduler: RTL and testbench

Sequences the UART transmitter to dump the processor snapshot bus (registers, PC, data words, pipeline latches, clock counter) one byte at a time after a halt.
Sits between the snapshot bus and the UART TX handshake. The debug unit issues a single start pulse and receives a done pulse.
Owns the TX side while busy. The snapshot is frozen at start, so the MIPS clock may resume during transmission without corrupting the dump.

---
 rtl/bucket_tx_scheduler_pkg.sv | 35 +++
 rtl/bucket_byte_mux.sv | 40 ++++
 rtl/bucket_tx_scheduler.sv | 119 +++++++++++
 tb/tb_bucket_tx_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bucket_tx_scheduler_pkg.sv
// ============================================================================
// Module      : bucket_tx_scheduler_pkg
// Description : Shared state encoding, width helper and defaults for the
//               snapshot-to-UART dump scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bucket_tx_scheduler_pkg;

    localparam int NBIT_DATA_LEN_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XMIT = 1'b1
    } state_t;

    // Bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value - 1;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                n = n + 1;
                v = v >> 1;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bucket_byte_mux.sv
// ============================================================================
// Module      : bucket_byte_mux
// Description : Combinational byte selector over the frozen snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bucket_byte_mux
    import bucket_tx_scheduler_pkg::*;
#(
    parameter int NBIT_DATA_LEN = NBIT_DATA_LEN_DEFAULT,
    parameter int len_bucket    = 864,
    parameter int len_contador  = clogb2(len_bucket / NBIT_DATA_LEN)
) (
    input  logic [len_bucket-1:0]    i_shadow,
    input  logic [len_contador-1:0]  i_idx,
    output logic [NBIT_DATA_LEN-1:0] o_byte
);

    localparam int c_n_bytes = len_bucket / NBIT_DATA_LEN;

    logic [NBIT_DATA_LEN-1:0] w_bytes [c_n_bytes];

    generate
        for (genvar gi = 0; gi < c_n_bytes; gi++) begin : g_bytes
            assign w_bytes[gi] = i_shadow[gi*NBIT_DATA_LEN +: NBIT_DATA_LEN];
        end
    endgenerate

    // Indices past the last byte read as zero rather than aliasing.
    always_comb begin
        o_byte = '0;
        if (32'(i_idx) < c_n_bytes) begin
            o_byte = w_bytes[i_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/bucket_tx_scheduler.sv
// ============================================================================
// Module      : bucket_tx_scheduler
// Description : Freezes the snapshot bus on start and feeds it LSB byte first
//               to the UART transmitter, pulsing done after the last byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bucket_tx_scheduler
    import bucket_tx_scheduler_pkg::*;
#(
    parameter int NBIT_DATA_LEN = NBIT_DATA_LEN_DEFAULT,
    parameter int len_bucket    = 864,
    parameter int len_contador  = clogb2(len_bucket / NBIT_DATA_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [len_bucket-1:0]    bucket,
    input  logic                     tx_done_tick,
    output logic                     tx_start,
    output logic [NBIT_DATA_LEN-1:0] data_out,
    output logic                     busy,
    output logic                     done,
    output logic [len_contador-1:0]  byte_idx
);

    localparam int                      c_n_bytes  = len_bucket / NBIT_DATA_LEN;
    localparam logic [len_contador-1:0] c_last_idx = len_contador'(c_n_bytes - 1);

    state_t                   r_state,    w_state_nxt;
    logic [len_bucket-1:0]    r_shadow,   w_shadow_nxt;
    logic                     r_tx_start, w_tx_start_nxt;
    logic [NBIT_DATA_LEN-1:0] r_data_out, w_data_out_nxt;
    logic                     r_busy,     w_busy_nxt;
    logic                     r_done,     w_done_nxt;
    logic [len_contador-1:0]  r_byte_idx, w_byte_idx_nxt;
    logic [len_contador-1:0]  w_idx_inc;
    logic [NBIT_DATA_LEN-1:0] w_next_byte;

    assign w_idx_inc = r_byte_idx + len_contador'(1);

    bucket_byte_mux #(
        .NBIT_DATA_LEN (NBIT_DATA_LEN),
        .len_bucket    (len_bucket),
        .len_contador  (len_contador)
    ) u_byte_mux (
        .i_shadow (r_shadow),
        .i_idx    (w_idx_inc),
        .o_byte   (w_next_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shadow   <= '0;
            r_tx_start <= 1'b0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_byte_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_data_out <= w_data_out_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_byte_idx <= w_byte_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_nxt   = r_shadow;
        w_tx_start_nxt = 1'b0;
        w_data_out_nxt = r_data_out;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_byte_idx_nxt = r_byte_idx;
        unique case (r_state)
            ST_IDLE: begin
                // A start overlapping the done pulse is dropped.
                if (start && !r_done) begin
                    w_shadow_nxt   = bucket;
                    w_byte_idx_nxt = '0;
                    w_data_out_nxt = bucket[NBIT_DATA_LEN-1:0];
                    w_tx_start_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_XMIT;
                end
            end
            ST_XMIT: begin
                // The UART cannot finish a byte in the cycle it is loaded.
                if (tx_done_tick && !r_tx_start) begin
                    if (r_byte_idx == c_last_idx) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_byte_idx_nxt = w_idx_inc;
                        w_data_out_nxt = w_next_byte;
                        w_tx_start_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign tx_start = r_tx_start;
    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign byte_idx = r_byte_idx;

endmodule

`default_nettype wire

// File: tb/tb_bucket_tx_scheduler.sv
// ============================================================================
// Module      : tb_bucket_tx_scheduler
// Description : Directed bench for a 3-byte and the default 108-byte dump.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bucket_tx_scheduler;

    logic clk;
    logic reset;

    logic        s_start, s_tdt, s_txs, s_busy, s_done;
    logic [23:0] s_bucket;
    logic [7:0]  s_dout;
    logic [1:0]  s_idx;

    logic         b_start, b_tdt, b_txs, b_busy, b_done;
    logic [863:0] b_bucket;
    logic [7:0]   b_dout;
    logic [6:0]   b_idx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] s_bytes[$];
    int         s_pulses, s_dones, s_stepno, s_tick_step, s_done_step, s_cnt;
    logic [1:0] s_idx_mid;

    bucket_tx_scheduler #(
        .NBIT_DATA_LEN (8),
        .len_bucket    (24),
        .len_contador  (2)
    ) u_small (
        .clk          (clk),
        .reset        (reset),
        .start        (s_start),
        .bucket       (s_bucket),
        .tx_done_tick (s_tdt),
        .tx_start     (s_txs),
        .data_out     (s_dout),
        .busy         (s_busy),
        .done         (s_done),
        .byte_idx     (s_idx)
    );

    bucket_tx_scheduler u_big (
        .clk          (clk),
        .reset        (reset),
        .start        (b_start),
        .bucket       (b_bucket),
        .tx_done_tick (b_tdt),
        .tx_start     (b_txs),
        .data_out     (b_dout),
        .busy         (b_busy),
        .done         (b_done),
        .byte_idx     (b_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of the small-DUT UART model: answers each tx_start 10 cycles later.
    task automatic s_step();
        @(negedge clk);
        s_stepno++;
        s_start = 1'b0;
        s_tdt   = 1'b0;
        if (s_done) begin
            s_dones++;
            s_done_step = s_stepno;
        end
        if (s_txs) begin
            s_bytes.push_back(s_dout);
            s_pulses++;
            s_cnt = 10;
        end else if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) begin
                s_tdt       = 1'b1;
                s_tick_step = s_stepno;
            end
        end
    endtask

    task automatic s_clear();
        s_bytes.delete();
        s_pulses = 0;
        s_dones  = 0;
    endtask

    function automatic logic [23:0] s_packed();
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < s_bytes.size() && i < 3; i++) begin
            v[23-8*i -: 8] = s_bytes[i];
        end
        return v;
    endfunction

    task automatic s_run_to_done(input bit midstart, output bit timeout);
        bit mid_done, mid_armed;
        timeout   = 1'b1;
        mid_done  = 1'b0;
        mid_armed = 1'b0;
        for (int i = 0; i < 200; i++) begin
            s_step();
            if (mid_armed) begin
                s_idx_mid = s_idx;
                mid_armed = 1'b0;
            end
            if (s_dones > 0) begin
                timeout = 1'b0;
                break;
            end
            if (midstart && !mid_done && s_idx == 2'd1) begin
                s_start   = 1'b1;
                mid_done  = 1'b1;
                mid_armed = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({s_txs, s_dout, s_busy, s_done, s_idx} !== 13'd0) begin
            $display("FAIL reset_small: got txs=%b dout=%h busy=%b done=%b idx=%0d, want all 0",
                     s_txs, s_dout, s_busy, s_done, s_idx);
        end else n_pass++;
        n_checks++;
        if ({b_txs, b_dout, b_busy, b_done, b_idx} !== 18'd0) begin
            $display("FAIL reset_big: got txs=%b dout=%h busy=%b done=%b idx=%0d, want all 0",
                     b_txs, b_dout, b_busy, b_done, b_idx);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        s_tdt = 1'b1;
        b_tdt = 1'b1;
        s_step();
        b_tdt = 1'b0;
        s_step();
        n_checks++;
        if ({s_txs, s_busy, b_txs, b_busy} !== 4'b0000) begin
            $display("FAIL idle_tick: got s_txs=%b s_busy=%b b_txs=%b b_busy=%b, want 0000",
                     s_txs, s_busy, b_txs, b_busy);
        end else n_pass++;
    endtask

    task automatic test_small_dump();
        bit to;
        s_clear();
        s_bucket = 24'hC3B2A1;
        s_start  = 1'b1;
        s_step();
        n_checks++;
        if (s_txs !== 1'b1 || s_dout !== 8'hA1 || s_busy !== 1'b1) begin
            $display("FAIL first_latency: got txs=%b dout=%h busy=%b, want 1 a1 1", s_txs, s_dout, s_busy);
        end else n_pass++;
        s_step();
        n_checks++;
        if (s_txs !== 1'b0) begin
            $display("FAIL txs_width: got %b, want 0", s_txs);
        end else n_pass++;
        s_run_to_done(1'b0, to);
        n_checks++;
        if (to !== 1'b0) $display("FAIL small_timeout: got timeout=%b, want 0", to);
        else n_pass++;
        n_checks++;
        if (s_pulses !== 3 || s_packed() !== 24'hA1B2C3) begin
            $display("FAIL small_bytes: got %0d pulses %h, want 3 a1b2c3", s_pulses, s_packed());
        end else n_pass++;
        n_checks++;
        if (s_done_step - s_tick_step !== 1 || s_busy !== 1'b0 || s_idx !== 2'd2) begin
            $display("FAIL done_timing: got gap=%0d busy=%b idx=%0d, want 1 0 2",
                     s_done_step - s_tick_step, s_busy, s_idx);
        end else n_pass++;
        s_step();
        n_checks++;
        if (s_done !== 1'b0 || s_idx !== 2'd2) begin
            $display("FAIL done_pulse: got done=%b idx=%0d, want 0 2", s_done, s_idx);
        end else n_pass++;
    endtask

    task automatic test_freeze();
        bit to;
        s_clear();
        s_bucket = 24'hC3B2A1;
        s_start  = 1'b1;
        s_step();
        s_bucket = 24'hFFFFFF;
        s_run_to_done(1'b0, to);
        n_checks++;
        if (to !== 1'b0 || s_pulses !== 3 || s_packed() !== 24'hA1B2C3) begin
            $display("FAIL freeze: got to=%b %0d pulses %h, want 0 3 a1b2c3", to, s_pulses, s_packed());
        end else n_pass++;
        s_step();
    endtask

    task automatic test_start_while_busy();
        bit to;
        s_clear();
        s_bucket  = 24'hC3B2A1;
        s_idx_mid = 2'd3;
        s_start   = 1'b1;
        s_step();
        s_bucket  = 24'h123456;
        s_run_to_done(1'b1, to);
        n_checks++;
        if (to !== 1'b0 || s_pulses !== 3 || s_packed() !== 24'hA1B2C3 || s_idx_mid !== 2'd1) begin
            $display("FAIL busy_start: got to=%b %0d pulses %h idx=%0d, want 0 3 a1b2c3 1",
                     to, s_pulses, s_packed(), s_idx_mid);
        end else n_pass++;
        // Start overlapping the done pulse: dropped.
        s_start = 1'b1;
        s_step();
        n_checks++;
        if (s_txs !== 1'b0 || s_busy !== 1'b0) begin
            $display("FAIL start_on_done: got txs=%b busy=%b, want 0 0", s_txs, s_busy);
        end else n_pass++;
        s_clear();
        s_start = 1'b1;
        s_step();
        n_checks++;
        if (s_txs !== 1'b1 || s_dout !== 8'h56 || s_idx !== 2'd0) begin
            $display("FAIL start_after_done: got txs=%b dout=%h idx=%0d, want 1 56 0", s_txs, s_dout, s_idx);
        end else n_pass++;
        s_run_to_done(1'b0, to);
        s_step();
    endtask

    task automatic test_reset_mid();
        bit to;
        bit hit;
        s_clear();
        s_bucket = 24'hC3B2A1;
        s_start  = 1'b1;
        s_step();
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            s_step();
            if (s_idx == 2'd1) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (hit !== 1'b1) $display("FAIL reach_idx1: got hit=%b, want 1", hit);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({s_txs, s_dout, s_busy, s_done, s_idx} !== 13'd0) begin
            $display("FAIL reset_mid: got txs=%b dout=%h busy=%b done=%b idx=%0d, want all 0",
                     s_txs, s_dout, s_busy, s_done, s_idx);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        s_cnt = 0;
        s_tdt = 1'b0;
        s_clear();
        s_start = 1'b1;
        s_step();
        s_run_to_done(1'b0, to);
        n_checks++;
        if (to !== 1'b0 || s_pulses !== 3 || s_packed() !== 24'hA1B2C3) begin
            $display("FAIL restart: got to=%b %0d pulses %h, want 0 3 a1b2c3", to, s_pulses, s_packed());
        end else n_pass++;
        s_step();
    endtask

    task automatic test_default_size();
        int   n_bytes, n_bad, n_done, cnt;
        logic [6:0] idx_at_done;
        bit   finished;
        for (int i = 0; i < 108; i++) b_bucket[i*8 +: 8] = 8'(i);
        n_bytes = 0; n_bad = 0; n_done = 0; cnt = 0;
        idx_at_done = '0;
        finished = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            b_tdt   = 1'b0;
            if (b_done) begin
                n_done++;
                if (!finished) idx_at_done = b_idx;
                finished = 1'b1;
            end
            if (b_txs) begin
                if (b_dout !== 8'(n_bytes)) n_bad++;
                n_bytes++;
                cnt = 4;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) b_tdt = 1'b1;
            end
            if (finished && c > 0 && n_done > 0 && !b_done && cnt == 0) break;
        end
        repeat (10) begin
            @(negedge clk);
            if (b_done) n_done++;
            if (b_txs) n_bytes++;
        end
        n_checks++;
        if (n_bytes !== 108 || n_bad !== 0) begin
            $display("FAIL big_bytes: got %0d bytes %0d wrong, want 108 0", n_bytes, n_bad);
        end else n_pass++;
        n_checks++;
        if (n_done !== 1 || idx_at_done !== 7'd107 || b_busy !== 1'b0) begin
            $display("FAIL big_done: got dones=%0d idx=%0d busy=%b, want 1 107 0", n_done, idx_at_done, b_busy);
        end else n_pass++;
    endtask

    initial begin
        reset    = 1'b0;
        s_start  = 1'b0;
        s_tdt    = 1'b0;
        s_bucket = '0;
        b_start  = 1'b0;
        b_tdt    = 1'b0;
        b_bucket = '0;
        s_cnt    = 0;
        s_stepno = 0;
        s_tick_step = 0;
        s_done_step = 0;
        s_idx_mid = '0;
        s_clear();
        test_reset();
        test_small_dump();
        test_freeze();
        test_start_while_busy();
        test_reset_mid();
        test_default_size();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
